// File: rtl/synth_reset_sequencer.sv
// rtl/synth_reset_sequencer.sv - staged startup/reset sequencer with debounced soft reset
// Optional macro SYNTH_SOFT_RESEQ_EN: a soft press restarts and replays the whole sequence.
module synth_reset_sequencer #(
  parameter int N_STAGES   = 3,
  parameter int CNT_WIDTH  = 11,
  parameter int STAGE_STEP = 4,
  parameter int INIT_LEN   = 12,
  parameter int PULSE_AT   = 200,
  parameter int PULSE_LEN  = 1,
  parameter int CNT_MAX    = 500,
  parameter int DEB_LEN    = 4
) (
  input  logic                 sysclk,
  input  logic                 reset1,
  input  logic                 soft_rst_n_in,
  output logic [N_STAGES-1:0]  rst_n_out,
  output logic                 sys_rst_n,
  output logic                 init_active,
  output logic                 soft_active,
  output logic                 seq_done,
  output logic [CNT_WIDTH-1:0] cnt_out
);

  typedef enum logic [1:0] {RAMP, PULSE, RUN} state_t;

  localparam int DEB_W = $clog2(DEB_LEN + 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_START = CNT_WIDTH'(PULSE_AT);
  localparam logic [CNT_WIDTH-1:0] PULSE_END   = CNT_WIDTH'(PULSE_AT + PULSE_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT   = CNT_WIDTH'(CNT_MAX);
  localparam logic [CNT_WIDTH-1:0] INIT_END    = CNT_WIDTH'(INIT_LEN);
  localparam logic [DEB_W-1:0]     DEB_LAST    = DEB_W'(DEB_LEN - 1);

  if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_stages
    $error("N_STAGES must be 1..8");
  end
  if (N_STAGES * STAGE_STEP >= PULSE_AT) begin : g_bad_step
    $error("N_STAGES*STAGE_STEP must be below PULSE_AT");
  end
  if (PULSE_AT + PULSE_LEN > CNT_MAX) begin : g_bad_pulse
    $error("PULSE_AT+PULSE_LEN must not exceed CNT_MAX");
  end
  if (CNT_MAX >= 2 ** CNT_WIDTH || PULSE_LEN < 1 || DEB_LEN < 1) begin : g_bad_width
    $error("CNT_MAX must fit CNT_WIDTH; PULSE_LEN and DEB_LEN must be >= 1");
  end

  logic [1:0]           rst_sync;
  logic                 rst_n;
  logic [1:0]           soft_sync;
  logic [DEB_W-1:0]     deb_cnt;
  logic                 pressed;
  logic                 soft_next;
  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [N_STAGES-1:0]  rst_next;
  logic                 sys_next, init_next, done_next;

  // Assert immediately with reset1, release two sysclk edges later.
  always_ff @(posedge sysclk or negedge reset1) begin
    if (!reset1) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign pressed = ~soft_sync[1];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      soft_sync <= 2'b11;
      deb_cnt   <= '0;
    end else begin
      soft_sync <= {soft_sync[0], soft_rst_n_in};
      if (pressed == soft_active || deb_cnt == DEB_LAST) deb_cnt <= '0;
      else                                               deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign soft_next = (pressed != soft_active && deb_cnt == DEB_LAST) ? pressed : soft_active;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RAMP;
      cnt_out     <= '0;
      rst_n_out   <= '0;
      sys_rst_n   <= 1'b0;
      init_active <= 1'b1;
      soft_active <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt_out     <= cnt_next;
      rst_n_out   <= rst_next;
      sys_rst_n   <= sys_next;
      init_active <= init_next;
      soft_active <= soft_next;
      seq_done    <= done_next;
    end
  end

  always_comb begin
    cnt_next   = (cnt_out == CNT_LIMIT) ? cnt_out : cnt_out + 1'b1;
    state_next = state;
    case (state)
      RAMP:    if (cnt_next == PULSE_START) state_next = PULSE;
      PULSE:   if (cnt_next == PULSE_END)   state_next = RUN;
      default: state_next = RUN;
    endcase
`ifdef SYNTH_SOFT_RESEQ_EN
    if (soft_active) begin
      cnt_next   = '0;
      state_next = RAMP;
    end
`endif
  end

  // Decode from the next-state counter so registered outputs always match cnt_out.
  always_comb begin
    rst_next = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      rst_next[k] = int'(cnt_next) >= (k + 1) * STAGE_STEP;
    end
    sys_next  = !(state_next == PULSE || soft_next);
    init_next = cnt_next < INIT_END;
    done_next = cnt_next == CNT_LIMIT;
  end

endmodule

// File: tb/tb_synth_reset_sequencer.sv
// tb/tb_synth_reset_sequencer.sv - randomized self-checking bench for synth_reset_sequencer
module tb_synth_reset_sequencer;
  localparam int N_STAGES   = 3;
  localparam int CNT_WIDTH  = 11;
  localparam int STAGE_STEP = 4;
  localparam int INIT_LEN   = 12;
  localparam int PULSE_AT   = 200;
  localparam int PULSE_LEN  = 1;
  localparam int CNT_MAX    = 500;
  localparam int DEB_LEN    = 4;
  localparam int OW = N_STAGES + 4 + CNT_WIDTH;

  logic sysclk = 1'b0;
  logic reset1 = 1'b0;
  logic soft_rst_n_in = 1'b1;
  logic [N_STAGES-1:0]  rst_n_out;
  logic                 sys_rst_n, init_active, soft_active, seq_done;
  logic [CNT_WIDTH-1:0] cnt_out;

  synth_reset_sequencer #(
    .N_STAGES(N_STAGES), .CNT_WIDTH(CNT_WIDTH), .STAGE_STEP(STAGE_STEP), .INIT_LEN(INIT_LEN),
    .PULSE_AT(PULSE_AT), .PULSE_LEN(PULSE_LEN), .CNT_MAX(CNT_MAX), .DEB_LEN(DEB_LEN)
  ) dut (
    .sysclk(sysclk), .reset1(reset1), .soft_rst_n_in(soft_rst_n_in),
    .rst_n_out(rst_n_out), .sys_rst_n(sys_rst_n), .init_active(init_active),
    .soft_active(soft_active), .seq_done(seq_done), .cnt_out(cnt_out)
  );

  always #5 sysclk = ~sysclk;

  int compared = 0;
  int mismatched = 0;

  int m_cnt;
  bit m_soft;
  bit raw_q[$];
  bit held_q[$];
  logic [OW-1:0] exp_v;
  logic [OW-1:0] reset_v;
  wire  [OW-1:0] obs_v = {rst_n_out, sys_rst_n, init_active, soft_active, seq_done, cnt_out};

  // Expected outputs straight from the documented decode rules.
  function automatic logic [OW-1:0] expect_outputs(int c, bit s);
    logic [N_STAGES-1:0] st;
    bit in_pulse;
    for (int k = 0; k < N_STAGES; k++) st[k] = (c >= (k + 1) * STAGE_STEP);
    in_pulse = (c >= PULSE_AT) && (c < PULSE_AT + PULSE_LEN);
    return {st, ~(in_pulse | s), (c < INIT_LEN), s, (c == CNT_MAX), CNT_WIDTH'(c)};
  endfunction

  task automatic apply_reset(input int low_cycles);
    soft_rst_n_in = 1'b1;
    reset1 = 1'b0;
    repeat (low_cycles) @(posedge sysclk);
    #1 reset1 = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    m_cnt  = 0;
    m_soft = 1'b0;
    raw_q  = '{1'b1, 1'b1};
    held_q = '{};
  endtask

  // One sysclk with the given raw button level; advances the reference model.
  task automatic step(input bit raw);
    bit prev_soft;
    bit all_same;
    soft_rst_n_in = raw;
    @(posedge sysclk);
    raw_q.push_back(raw);
    held_q.push_back(raw_q[raw_q.size() - 3]);
    prev_soft = m_soft;
    if (held_q.size() >= DEB_LEN) begin
      all_same = 1'b1;
      for (int i = 1; i <= DEB_LEN; i++)
        if (held_q[held_q.size() - i] != held_q[held_q.size() - 1]) all_same = 1'b0;
      if (all_same) m_soft = ~held_q[held_q.size() - 1];
    end
`ifdef SYNTH_SOFT_RESEQ_EN
    if (prev_soft) m_cnt = 0;
    else if (m_cnt < CNT_MAX) m_cnt++;
`else
    if (m_cnt < CNT_MAX) m_cnt++;
`endif
    exp_v = expect_outputs(m_cnt, m_soft);
    #1;
  endtask

  task automatic test_reset();
    reset1 = 1'b0;
    #1;
    compared++;
    if (obs_v !== reset_v) begin
      mismatched++;
      $display("FAIL reset_async: got %h want %h", obs_v, reset_v);
    end
    apply_reset(3);
    compared++;
    if (obs_v !== reset_v) begin
      mismatched++;
      $display("FAIL reset_release_hold: got %h want %h", obs_v, reset_v);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL reset_ramp cnt=%0d: got %h want %h", m_cnt, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_pulse_saturate();
    int low = 0;
    for (int i = 0; i < CNT_MAX + 100; i++) begin
      step(1'b1);
      if (sys_rst_n === 1'b0) low++;
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL pulse_saturate cnt=%0d: got %h want %h", m_cnt, obs_v, exp_v);
      end
    end
    compared++;
    if (low !== PULSE_LEN) begin
      mismatched++;
      $display("FAIL pulse_width: got %0d want %0d", low, PULSE_LEN);
    end
  endtask

  task automatic test_soft_glitch();
    int rise_at = -1;
    int sys_back = -1;
    for (int g = 0; g < 6; g++) begin
      int len = $urandom_range(DEB_LEN - 1, 1);
      for (int i = 0; i < len + 10; i++) begin
        step(i < len ? 1'b0 : 1'b1);
        compared++;
        if (obs_v !== exp_v) begin
          mismatched++;
          $display("FAIL soft_glitch len=%0d: got %h want %h", len, obs_v, exp_v);
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      if (soft_active === 1'b1 && rise_at < 0) rise_at = i + 1;
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL soft_press: got %h want %h", obs_v, exp_v);
      end
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b1);
      if (sys_rst_n === 1'b1 && sys_back < 0) sys_back = i + 1;
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL soft_release: got %h want %h", obs_v, exp_v);
      end
    end
    compared++;
    if (rise_at !== DEB_LEN + 2) begin
      mismatched++;
      $display("FAIL soft_latency: got %0d want %0d", rise_at, DEB_LEN + 2);
    end
    compared++;
    if (sys_back !== DEB_LEN + 2) begin
      mismatched++;
      $display("FAIL soft_release_latency: got %0d want %0d", sys_back, DEB_LEN + 2);
    end
  endtask

  task automatic test_random_soft();
    bit lvl = 1'b1;
    int run = 0;
    apply_reset(2);
    for (int i = 0; i < 700; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(12, 1);
      end
      run--;
      step(lvl);
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL random_soft i=%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_midreset();
    apply_reset(3);
    while (m_cnt < 150) step(1'b1);
    #2 reset1 = 1'b0;
    #1;
    compared++;
    if (obs_v !== reset_v) begin
      mismatched++;
      $display("FAIL midreset_abort: got %h want %h", obs_v, reset_v);
    end
    apply_reset(2);
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL midreset_restart: got %h want %h", obs_v, exp_v);
      end
    end
    compared++;
    if (rst_n_out !== {N_STAGES{1'b1}} || cnt_out !== CNT_WIDTH'(12)) begin
      mismatched++;
      $display("FAIL midreset_stages: got %b/%0d want all ones/12", rst_n_out, cnt_out);
    end
  endtask

  initial begin
    reset_v = {{N_STAGES{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, {CNT_WIDTH{1'b0}}};
    exp_v = reset_v;
    #12;
    test_reset();
    test_pulse_saturate();
    test_soft_glitch();
    test_random_soft();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
